// File: rtl/cam_inbuf_writer_if.sv
// Camera byte stream in, input-buffer write port out.
// Signal names follow the block's external pin names.
interface cam_inbuf_writer_if #(
   parameter int ADDR_W = 17
);
   logic              iVSync;
   logic              iHRef;
   logic              iPixEn;
   logic [7:0]        iData;
   logic              iCapReq;
   logic              iContinuous;
   logic              oWrEn;
   logic [ADDR_W-1:0] oWrAddr;
   logic [15:0]       oWrData;
   logic              oBusy;
   logic              oFrameDone;
   logic              oShortFrame;

   modport master (
      output iVSync, iHRef, iPixEn, iData,
      output iCapReq, iContinuous,
      input  oWrEn, oWrAddr, oWrData,
      input  oBusy, oFrameDone, oShortFrame
   );

   modport slave (
      input  iVSync, iHRef, iPixEn, iData,
      input  iCapReq, iContinuous,
      output oWrEn, oWrAddr, oWrData,
      output oBusy, oFrameDone, oShortFrame
   );
endinterface

// File: rtl/cam_inbuf_writer.sv
// RGB565 camera capture into the CNN input buffer, one word per pixel,
// cropped to WIDTH x HEIGHT, single-shot or continuous.
module cam_inbuf_writer #(
   parameter int WIDTH  = 480,
   parameter int HEIGHT = 272,
   parameter int ADDR_W = 17
) (
   input logic              iClk,
   input logic              iRsn,
   cam_inbuf_writer_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam int RW = $clog2(HEIGHT + 1);
   localparam logic [CW-1:0]     LC_W = CW'(WIDTH);
   localparam logic [RW-1:0]     LC_H = RW'(HEIGHT);
   localparam logic [ADDR_W-1:0] LA_W = ADDR_W'(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE, S_ARMED, S_CAPT, S_DONE
   } state_t;

   state_t r_state;
   state_t w_next;

   logic              r_vs_d;
   logic              r_hr_d;
   logic [RW-1:0]     r_row;
   logic [CW-1:0]     r_col;
   logic [ADDR_W-1:0] r_base;
   logic              r_phase;
   logic [7:0]        r_hi;
   logic              r_wr_en;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [15:0]       r_wr_data;
   logic              r_short;

   logic w_vs_fall;
   logic w_vs_rise;
   logic w_hr_fall;
   logic w_acc;
   logic w_in_win;

   assign w_vs_fall = r_vs_d & ~bus.iVSync;
   assign w_vs_rise = ~r_vs_d & bus.iVSync;
   assign w_hr_fall = r_hr_d & ~bus.iHRef;
   assign w_acc     = bus.iPixEn & bus.iHRef;
   assign w_in_win  = (r_col < LC_W) && (r_row < LC_H);

   always_ff @(posedge iClk or negedge iRsn) begin
      if (!iRsn) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (bus.iCapReq) w_next = S_ARMED;
         S_ARMED: if (w_vs_fall)   w_next = S_CAPT;
         S_CAPT:  if (w_vs_rise)   w_next = S_DONE;
         S_DONE:  w_next = bus.iContinuous ? S_ARMED : S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      bus.oBusy       = (r_state != S_IDLE);
      bus.oFrameDone  = (r_state == S_DONE);
      bus.oWrEn       = r_wr_en;
      bus.oWrAddr     = r_wr_addr;
      bus.oWrData     = r_wr_data;
      bus.oShortFrame = r_short;
   end

   always_ff @(posedge iClk or negedge iRsn) begin
      if (!iRsn) begin
         r_vs_d    <= 1'b0;
         r_hr_d    <= 1'b0;
         r_row     <= '0;
         r_col     <= '0;
         r_base    <= '0;
         r_phase   <= 1'b0;
         r_hi      <= '0;
         r_wr_en   <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
         r_short   <= 1'b0;
      end else begin
         r_vs_d  <= bus.iVSync;
         r_hr_d  <= bus.iHRef;
         r_wr_en <= 1'b0;
         if (r_state == S_IDLE && bus.iCapReq)
            r_short <= 1'b0;
         if (r_state == S_DONE && r_row < LC_H)
            r_short <= 1'b1;
         if (r_state == S_ARMED && w_vs_fall) begin
            r_row   <= '0;
            r_col   <= '0;
            r_base  <= '0;
            r_phase <= 1'b0;
         end
         if (r_state == S_CAPT) begin
            if (w_acc) begin
               r_phase <= ~r_phase;
               if (!r_phase) begin
                  r_hi <= bus.iData;
               end else begin
                  r_wr_en   <= w_in_win;
                  r_wr_addr <= r_base + ADDR_W'(r_col);
                  r_wr_data <= {bus.iData[4:0], r_hi[2:0],
                                bus.iData[7:5], r_hi[7:3]};
                  if (r_col < LC_W)
                     r_col <= r_col + 1'b1;
               end
            end
            // line end wins over the pixel's col/phase update
            if (w_hr_fall) begin
               r_col   <= '0;
               r_phase <= 1'b0;
               if (r_row < LC_H) begin
                  r_row  <= r_row + 1'b1;
                  r_base <= r_base + LA_W;
               end
            end
            if (w_vs_rise)
               r_phase <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_cam_inbuf_writer.sv
// Scoreboard bench for cam_inbuf_writer: random and directed frames
// checked against a pixel-list reference model.
module tb_cam_inbuf_writer;
   localparam int W  = 4;
   localparam int H  = 2;
   localparam int AW = 17;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   cam_inbuf_writer_if #(.ADDR_W(AW)) bus ();

   cam_inbuf_writer #(
      .WIDTH(W), .HEIGHT(H), .ADDR_W(AW)
   ) dut (
      .iClk(clk),
      .iRsn(rst_n),
      .bus(bus)
   );

   typedef struct {
      int          addr;
      logic [15:0] data;
   } wr_t;

   wr_t exp_q[$];
   int  checks = 0;
   int  errors = 0;
   int  done_cnt = 0;
   int  wr_cnt = 0;
   int  max_addr = 0;
   int  busy_gap = 0;
   bit  busy_watch = 0;

   logic [7:0] fhi[4][8];
   logic [7:0] flo[4][8];
   int         fnp[4];
   bit         fodd[4];
   int         fnl;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] pack(logic [7:0] hi, logic [7:0] lo);
      logic [4:0] r;
      logic [5:0] g;
      logic [4:0] b;
      r = hi[7:3];
      g = {hi[2:0], lo[7:5]};
      b = lo[4:0];
      return {b, g, r};
   endfunction

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.oFrameDone) done_cnt++;
         if (busy_watch && !bus.oBusy) busy_gap++;
         if (bus.oWrEn) begin
            wr_cnt++;
            if (int'(bus.oWrAddr) > max_addr) max_addr = int'(bus.oWrAddr);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: addr %0h data %0h, none required",
                        bus.oWrAddr, bus.oWrData);
            end else begin
               wr_t e;
               e = exp_q.pop_front();
               chk("wr_addr", 32'(bus.oWrAddr), e.addr);
               chk("wr_data", 32'(bus.oWrData), 32'(e.data));
            end
         end
      end
   end

   task automatic idle(int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(logic [7:0] b, bit expw);
      @(negedge clk);
      bus.iData  = b;
      bus.iPixEn = 1'b1;
      @(negedge clk);
      bus.iPixEn = 1'b0;
      if (expw) chk("wr_latency", 32'(bus.oWrEn), 1);
      idle($urandom_range(0, 2));
   endtask

   task automatic gen_line(int l, int np, bit od);
      fnp[l]  = np;
      fodd[l] = od;
      for (int p = 0; p < 8; p++) begin
         fhi[l][p] = 8'($urandom);
         flo[l][p] = 8'($urandom);
      end
   endtask

   task automatic const_line(int l, int np, logic [7:0] hi, logic [7:0] lo);
      fnp[l]  = np;
      fodd[l] = 1'b0;
      for (int p = 0; p < 8; p++) begin
         fhi[l][p] = hi;
         flo[l][p] = lo;
      end
   endtask

   task automatic drive_lines(bit cap);
      for (int l = 0; l < fnl; l++) begin
         @(negedge clk);
         bus.iHRef = 1'b1;
         idle(1);
         for (int p = 0; p < fnp[l]; p++) begin
            bit kept;
            kept = cap && (l < H) && (p < W);
            if (kept) exp_q.push_back('{l * W + p, pack(fhi[l][p], flo[l][p])});
            send_byte(fhi[l][p], 1'b0);
            send_byte(flo[l][p], kept);
         end
         if (fodd[l]) send_byte(8'($urandom), 1'b0);
         @(negedge clk);
         bus.iHRef = 1'b0;
         idle(2);
      end
   endtask

   task automatic run_frame(bit cap);
      @(negedge clk);
      bus.iVSync = 1'b0;
      idle(3);
      drive_lines(cap);
      @(negedge clk);
      bus.iVSync = 1'b1;
      idle(4);
   endtask

   task automatic arm();
      @(negedge clk);
      bus.iCapReq = 1'b1;
      @(negedge clk);
      bus.iCapReq = 1'b0;
   endtask

   initial begin
      int d0;
      int w0;
      bus.iVSync      = 1'b1;
      bus.iHRef       = 1'b0;
      bus.iPixEn      = 1'b0;
      bus.iData       = '0;
      bus.iCapReq     = 1'b0;
      bus.iContinuous = 1'b0;

      idle(3);
      chk("rst_wren", 32'(bus.oWrEn), 0);
      chk("rst_addr", 32'(bus.oWrAddr), 0);
      chk("rst_data", 32'(bus.oWrData), 0);
      chk("rst_busy", 32'(bus.oBusy), 0);
      chk("rst_done", 32'(bus.oFrameDone), 0);
      chk("rst_short", 32'(bus.oShortFrame), 0);
      rst_n = 1'b1;
      idle(2);

      // two full lines of magenta
      d0 = done_cnt;
      fnl = 2;
      const_line(0, 4, 8'hF8, 8'h1F);
      const_line(1, 4, 8'hF8, 8'h1F);
      arm();
      chk("busy_after_arm", 32'(bus.oBusy), 1);
      run_frame(1'b1);
      chk("t1_pending", exp_q.size(), 0);
      chk("t1_done", done_cnt - d0, 1);
      chk("t1_busy", 32'(bus.oBusy), 0);
      chk("t1_short", 32'(bus.oShortFrame), 0);

      // single green pixel, one line only
      d0 = done_cnt;
      fnl = 1;
      const_line(0, 1, 8'h07, 8'hE0);
      arm();
      run_frame(1'b1);
      chk("t2_pending", exp_q.size(), 0);
      chk("t2_done", done_cnt - d0, 1);
      chk("t2_short", 32'(bus.oShortFrame), 1);

      // crop: 3 lines x 6 pixels
      d0 = done_cnt;
      w0 = wr_cnt;
      max_addr = 0;
      fnl = 3;
      for (int l = 0; l < 3; l++) gen_line(l, 6, 1'b0);
      arm();
      chk("t3_short_clr", 32'(bus.oShortFrame), 0);
      run_frame(1'b1);
      chk("t3_writes", wr_cnt - w0, 8);
      chk("t3_max_addr", max_addr, 7);
      chk("t3_pending", exp_q.size(), 0);
      chk("t3_short", 32'(bus.oShortFrame), 0);

      // short first line with stray odd byte
      w0 = wr_cnt;
      fnl = 2;
      gen_line(0, 2, 1'b1);
      gen_line(1, 4, 1'b0);
      arm();
      run_frame(1'b1);
      chk("t4_writes", wr_cnt - w0, 6);
      chk("t4_pending", exp_q.size(), 0);

      // arm in the middle of a frame
      d0 = done_cnt;
      w0 = wr_cnt;
      fnl = 1;
      gen_line(0, 3, 1'b0);
      @(negedge clk);
      bus.iVSync = 1'b0;
      idle(3);
      drive_lines(1'b0);
      arm();
      drive_lines(1'b0);
      @(negedge clk);
      bus.iVSync = 1'b1;
      idle(4);
      chk("t5_no_writes", wr_cnt - w0, 0);
      chk("t5_no_done", done_cnt - d0, 0);
      chk("t5_busy", 32'(bus.oBusy), 1);
      gen_line(0, 4, 1'b0);
      run_frame(1'b1);
      chk("t5_done", done_cnt - d0, 1);
      chk("t5_pending", exp_q.size(), 0);

      // continuous mode
      d0 = done_cnt;
      bus.iContinuous = 1'b1;
      arm();
      busy_watch = 1'b1;
      busy_gap = 0;
      for (int f = 0; f < 2; f++) begin
         fnl = 2;
         gen_line(0, $urandom_range(1, 6), 1'($urandom));
         gen_line(1, $urandom_range(1, 6), 1'($urandom));
         run_frame(1'b1);
      end
      busy_watch = 1'b0;
      chk("t6_done2", done_cnt - d0, 2);
      chk("t6_busy_gap", busy_gap, 0);
      chk("t6_pending", exp_q.size(), 0);
      bus.iContinuous = 1'b0;
      fnl = 1;
      gen_line(0, 2, 1'b0);
      run_frame(1'b1);
      chk("t6_done3", done_cnt - d0, 3);
      chk("t6_busy_end", 32'(bus.oBusy), 0);

      // randomized frames
      for (int f = 0; f < 6; f++) begin
         d0 = done_cnt;
         fnl = $urandom_range(1, 3);
         for (int l = 0; l < fnl; l++)
            gen_line(l, $urandom_range(1, 6), 1'($urandom));
         arm();
         run_frame(1'b1);
         chk("rnd_pending", exp_q.size(), 0);
         chk("rnd_done", done_cnt - d0, 1);
         chk("rnd_short", 32'(bus.oShortFrame), 32'(fnl < H));
         chk("rnd_busy", 32'(bus.oBusy), 0);
      end

      // reset in the middle of a line
      d0 = done_cnt;
      w0 = wr_cnt;
      fnl = 1;
      gen_line(0, 4, 1'b0);
      arm();
      @(negedge clk);
      bus.iVSync = 1'b0;
      idle(3);
      @(negedge clk);
      bus.iHRef = 1'b1;
      idle(1);
      for (int p = 0; p < 2; p++) begin
         exp_q.push_back('{p, pack(fhi[0][p], flo[0][p])});
         send_byte(fhi[0][p], 1'b0);
         send_byte(flo[0][p], 1'b1);
      end
      exp_q.push_back('{2, pack(fhi[0][2], flo[0][2])});
      send_byte(fhi[0][2], 1'b0);
      @(negedge clk);
      bus.iData  = flo[0][2];
      bus.iPixEn = 1'b1;
      @(negedge clk);
      bus.iPixEn = 1'b0;
      chk("t8_wren_pre", 32'(bus.oWrEn), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("t8_async_wren", 32'(bus.oWrEn), 0);
      chk("t8_async_addr", 32'(bus.oWrAddr), 0);
      chk("t8_async_data", 32'(bus.oWrData), 0);
      chk("t8_async_busy", 32'(bus.oBusy), 0);
      @(negedge clk);
      rst_n = 1'b1;
      send_byte(fhi[0][3], 1'b0);
      send_byte(flo[0][3], 1'b0);
      @(negedge clk);
      bus.iHRef = 1'b0;
      idle(2);
      @(negedge clk);
      bus.iVSync = 1'b1;
      idle(4);
      chk("t8_writes", wr_cnt - w0, 3);
      chk("t8_pending", exp_q.size(), 0);
      chk("t8_no_done", done_cnt - d0, 0);
      chk("t8_idle_busy", 32'(bus.oBusy), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
